// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes (also used by the decoder) and the
// execution-unit FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_OR   = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    function automatic logic is_legal(input logic [3:0] code);
        return (code == ALU_OR)  || (code == ALU_AND) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT) || (code == ALU_SLTU) ||
               is_shift(code);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Request/response handshake bundle between the core and the ALU execution unit.
// master = core side, slave = execution unit side.
interface alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: working register plus remaining-shift counter.
// dout is the value after the next step; done flags the final step.
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dir,
    input  logic               arith,
    input  logic [XLEN-1:0]    din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    dout,
    output logic               done
);

    logic [XLEN-1:0]    work;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_q;
    logic               arith_q;
    logic               fill;

    assign fill = arith_q & work[XLEN-1];
    assign dout = dir_q ? {fill, work[XLEN-1:1]} : {work[XLEN-2:0], 1'b0};
    assign done = (cnt == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= shamt;
        else if (cnt != '0)
            cnt <= cnt - SHAMT_W'(1);
    end

    // Datapath register: no reset, only meaningful while cnt is non-zero.
    always_ff @(posedge clk) begin
        if (load) begin
            work    <= din;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (cnt != '0) begin
            work <= dout;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: decodes ALUControl, computes result/zero/illegal behind a valid/ready
// handshake. Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts instead of serial shifting.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  io,
    output logic  busy
);

    alu_state_t                state;
    logic                      accept;
    logic [SHAMT_W-1:0]        shamt;
    logic signed [XLEN-1:0]    a_s;
    logic signed [XLEN-1:0]    b_s;
    logic [XLEN-1:0]           op_res;

    assign io.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && io.out_ready);
    assign accept      = io.in_valid && io.in_ready;
    assign shamt       = io.src_b[SHAMT_W-1:0];
    assign a_s         = io.src_a;
    assign b_s         = io.src_b;

    always_comb begin
        op_res = '0;
        case (io.alu_ctrl)
            ALU_OR:   op_res = io.src_a | io.src_b;
            ALU_AND:  op_res = io.src_a & io.src_b;
            ALU_ADD:  op_res = io.src_a + io.src_b;
            ALU_SUB:  op_res = io.src_a - io.src_b;
            ALU_SLT:  op_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: op_res = {{(XLEN-1){1'b0}}, (io.src_a < io.src_b)};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  op_res = io.src_a << shamt;
            ALU_SRL:  op_res = io.src_a >> shamt;
            ALU_SRA:  op_res = $unsigned(a_s >>> shamt);
`else
            // Reached only for shamt == 0; non-zero amounts go through the serial shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: op_res = io.src_a;
`endif
            default:  op_res = '0;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic            iter;
    logic            sh_done;
    logic [XLEN-1:0] sh_res;

    assign iter = is_shift(io.alu_ctrl) && (shamt != '0);

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && iter),
        .dir   (io.alu_ctrl != ALU_SLL),
        .arith (io.alu_ctrl == ALU_SRA),
        .din   (io.src_a),
        .shamt (shamt),
        .dout  (sh_res),
        .done  (sh_done)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            io.out_valid <= 1'b0;
            io.result    <= '0;
            io.zero      <= 1'b0;
            io.illegal   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        busy <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
                        if (iter) begin
                            state        <= ST_SHIFT;
                            io.out_valid <= 1'b0;
                        end else
`endif
                        begin
                            state        <= ST_DONE;
                            io.out_valid <= 1'b1;
                            io.result    <= op_res;
                            io.zero      <= (op_res == '0);
                            io.illegal   <= !is_legal(io.alu_ctrl);
                        end
                    end else if ((state == ST_DONE) && io.out_ready) begin
                        state        <= ST_IDLE;
                        io.out_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                ST_SHIFT: begin
                    if (sh_done) begin
                        state        <= ST_DONE;
                        io.out_valid <= 1'b1;
                        io.result    <= sh_res;
                        io.zero      <= (sh_res == '0);
                        io.illegal   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state        <= ST_IDLE;
                    io.out_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit (works with or without ALU_FAST_SHIFT_EN).
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    alu_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        il;
    } vec_t;

    vec_t vt[16];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if (is_shift(c) && (b[4:0] != 5'd0))
            return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic il,
                          output int lat, output logic rdy_bad);
        @(negedge clk);
        bus.alu_ctrl  = c;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat     = 0;
        rdy_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && bus.in_ready) rdy_bad = 1'b1;
        end while (!bus.out_valid && lat < 100);
        r  = bus.result;
        z  = bus.zero;
        il = bus.illegal;
    endtask

    logic [31:0] r;
    logic        z, il, rdy_bad, seen;
    int          lat;

    initial begin
        vt[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vt[1]  = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0};
        vt[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        vt[3]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vt[4]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0};
        vt[5]  = '{ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0};
        vt[6]  = '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0};
        vt[7]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vt[8]  = '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[9]  = '{ALU_SRL,  32'h8000_0000, 32'hFFFF_FF01, 32'h4000_0000, 1'b0, 1'b0};
        vt[10] = '{ALU_SLL,  32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0};
        vt[11] = '{4'b1111,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1};
        vt[12] = '{4'b0011,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vt[13] = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        vt[14] = '{ALU_SRA,  32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, 1'b0};
        vt[15] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0014, 32'h0000_0800, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    bus.result,         32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd0);
        chk("rst_illegal",   32'(bus.illegal),   32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vt[i].c, vt[i].a, vt[i].b, r, z, il, lat, rdy_bad);
            chk($sformatf("v%0d_result", i),  r,                   vt[i].res);
            chk($sformatf("v%0d_zero", i),    32'(z),              32'(vt[i].z));
            chk($sformatf("v%0d_illegal", i), 32'(il),             32'(vt[i].il));
            chk($sformatf("v%0d_latency", i), 32'(lat),            32'(exp_lat(vt[i].c, vt[i].b)));
            chk($sformatf("v%0d_rdy_in_shift", i), 32'(rdy_bad),   32'd0);
        end

        // Backpressure followed by a back-to-back accept in the same cycle as out_ready.
        @(negedge clk);
        bus.alu_ctrl  = ALU_SUB;
        bus.src_a     = 32'd5;
        bus.src_b     = 32'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_result", k),    bus.result,         32'd2);
            chk($sformatf("bp%0d_in_ready", k),  32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = ALU_OR;
        bus.src_a     = 32'h0000_00F0;
        bus.src_b     = 32'h0000_000F;
        bus.in_valid  = 1'b1;
        #1 chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_result",    bus.result,         32'h0000_00FF);
        @(negedge clk);
        chk("b2b_idle", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a long SRL.
        @(negedge clk);
        bus.alu_ctrl = ALU_SRL;
        bus.src_a    = 32'hFFFF_FFFF;
        bus.src_b    = 32'd20;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
`ifndef ALU_FAST_SHIFT_EN
        chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy",      32'(busy),          32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid || busy) seen = 1'b1;
        end
        chk("no_stale_result", 32'(seen),   32'd0);
        chk("post_rst_result", bus.result,  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
